// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store interface: word array, fixed
// access latency, RV32I byte/half/word lanes with sign/zero extension and error flagging.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic          enter_resp;

    logic          lat_we;
    logic [AW+1:0] lat_addr;
    logic [2:0]    lat_f3;
    logic [31:0]   lat_wdata;

    logic [31:0]   mem [DEPTH];

    // Request fields as seen on the RESP-entry edge; with LATENCY=1 that is
    // the accept edge itself, so the live inputs are used directly.
    logic          e_we;
    logic [AW+1:0] e_addr;
    logic [2:0]    e_f3;
    logic [31:0]   e_wdata;
    logic [AW-1:0] e_idx;
    logic [1:0]    e_lane;
    logic [31:0]   cur_word;
    logic [31:0]   byte_src;
    logic [7:0]    b_val;
    logic [15:0]   h_val;
    logic [31:0]   ld_data;
    logic [31:0]   st_word;
    logic          e_err;

    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                if (LATENCY == 1) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_nxt = BUSY;
                end
            end
            BUSY: if (cnt == 4'd0) begin
                state_nxt  = RESP;
                enter_resp = 1'b1;
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        e_we    = (state == IDLE) ? req_we               : lat_we;
        e_addr  = (state == IDLE) ? req_addr[AW+1:0]     : lat_addr;
        e_f3    = (state == IDLE) ? req_funct3           : lat_f3;
        e_wdata = (state == IDLE) ? req_wdata            : lat_wdata;
        e_idx   = e_addr[AW+1:2];
        e_lane  = e_addr[1:0];
        cur_word = mem[e_idx];
        byte_src = cur_word >> {e_lane, 3'b000};
        b_val    = byte_src[7:0];
        h_val    = e_lane[1] ? cur_word[31:16] : cur_word[15:0];

        case (e_f3)
            3'b000:  e_err = 1'b0;
            3'b001:  e_err = e_lane[0];
            3'b010:  e_err = (e_lane != 2'b00);
            3'b100:  e_err = e_we;
            3'b101:  e_err = e_we | e_lane[0];
            default: e_err = 1'b1;
        endcase

        case (e_f3)
            3'b000:  ld_data = {{24{b_val[7]}}, b_val};
            3'b001:  ld_data = {{16{h_val[15]}}, h_val};
            3'b010:  ld_data = cur_word;
            3'b100:  ld_data = {24'd0, b_val};
            3'b101:  ld_data = {16'd0, h_val};
            default: ld_data = 32'd0;
        endcase

        st_word = cur_word;
        case (e_f3)
            3'b000:  st_word[{e_lane, 3'b000} +: 8] = e_wdata[7:0];
            3'b001:  st_word[{e_lane[1], 4'b0000} +: 16] = e_wdata[15:0];
            3'b010:  st_word = e_wdata;
            default: st_word = cur_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_f3    <= 3'd0;
            lat_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cnt       <= 4'(LATENCY - 1);
                lat_we    <= req_we;
                lat_addr  <= req_addr[AW+1:0];
                lat_f3    <= req_funct3;
                lat_wdata <= req_wdata;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_resp) begin
                rsp_rdata <= (e_err || e_we) ? 32'd0 : ld_data;
                rsp_err   <= e_err;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Array has no reset; a store commits only if reset is not active on the entry edge.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && e_we && !e_err)
            mem[e_idx] <= st_word;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a word-array model predicts each
// response when the request is driven; results are popped when rsp_valid appears.
module tb_data_mem_responder;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [31:0] model [int];

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Reference behaviour: returns {err, rdata} and applies legal stores to the model.
    function automatic logic [32:0] model_op(input logic we, input logic [31:0] addr,
                                             input logic [2:0] f3, input logic [31:0] wdata);
        int          idx;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        logic        err;
        logic [31:0] rd;
        idx = int'((addr >> 2) % DEPTH);
        w   = model.exists(idx) ? model[idx] : 32'hx;
        b   = 8'(w >> (8 * addr[1:0]));
        h   = addr[1] ? w[31:16] : w[15:0];
        err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
              ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) ||
              (f3 == 3'b010 && addr[1:0] != 2'b00) ||
              (we && (f3 == 3'b100 || f3 == 3'b101));
        rd = 32'd0;
        if (!err && !we) begin
            case (f3)
                3'b000: rd = {{24{b[7]}}, b};
                3'b001: rd = {{16{h[15]}}, h};
                3'b010: rd = w;
                3'b100: rd = {24'd0, b};
                default: rd = {16'd0, h};
            endcase
        end
        if (!err && we) begin
            case (f3)
                3'b000: w[8*addr[1:0] +: 8] = wdata[7:0];
                3'b001: w[16*addr[1] +: 16] = wdata[15:0];
                default: w = wdata;
            endcase
            model[idx] = w;
        end
        return {err, rd};
    endfunction

    // One full transaction; hold = cycles rsp_ready stays low once rsp_valid is seen.
    // With poke=1 a conflicting store is presented during the hold and must be ignored.
    task automatic txn(input string name, input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wdata,
                       input int hold, input logic poke);
        int          lat;
        logic [32:0] exp;
        logic [31:0] first_rd;
        logic        first_err;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wdata;
        exp_q.push_back(model_op(we, addr, f3, wdata));
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != LATENCY) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, want %0d", name, lat, LATENCY);
        end
        if (!rsp_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        first_rd  = rsp_rdata;
        first_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (poke) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h000000A8;
                req_funct3 = 3'b010; req_wdata = 32'hffffffff;
            end
            @(posedge clk); #1;
            checks++;
            if (!rsp_valid || rsp_rdata !== first_rd || rsp_err !== first_err || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b, want 1 %h %b 0",
                         name, i, rsp_valid, rsp_rdata, rsp_err, req_ready, first_rd, first_err);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp[31:0] || rsp_err !== exp[32]) begin
            errors++;
            $display("FAIL %s rsp: rdata=%h err=%b, want rdata=%h err=%b",
                     name, rsp_rdata, rsp_err, exp[31:0], exp[32]);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ack: valid=%b rdata=%h err=%b ready=%b, want 0 0 0 1",
                     name, rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_funct3 = 3'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_word();
        txn("sw_init", 1'b1, 32'hA8, 3'b010, 32'hdeadbeef, 0, 1'b0);
        txn("lw_a8",   1'b0, 32'hA8, 3'b010, 32'h0, 0, 1'b0);
        txn("lw_wrap", 1'b0, 32'hA8 + DEPTH * 4, 3'b010, 32'h0, 0, 1'b0);
    endtask

    task automatic test_load_sizes();
        txn("lb_a9",  1'b0, 32'hA9, 3'b000, 32'h0, 0, 1'b0);
        txn("lbu_a9", 1'b0, 32'hA9, 3'b100, 32'h0, 0, 1'b0);
        txn("lhu_aa", 1'b0, 32'hAA, 3'b101, 32'h0, 0, 1'b0);
        txn("lh_aa",  1'b0, 32'hAA, 3'b001, 32'h0, 0, 1'b0);
        txn("lbu_a8", 1'b0, 32'hA8, 3'b100, 32'h0, 0, 1'b0);
    endtask

    task automatic test_store();
        txn("sb_ab",  1'b1, 32'hAB, 3'b000, 32'h00000012, 0, 1'b0);
        txn("lw_sb",  1'b0, 32'hA8, 3'b010, 32'h0, 0, 1'b0);
        txn("sh_a8",  1'b1, 32'hA8, 3'b001, 32'h00005555, 0, 1'b0);
        txn("lw_sh",  1'b0, 32'hA8, 3'b010, 32'h0, 0, 1'b0);
        txn("sw_1c",  1'b1, 32'h1C, 3'b010, 32'h0badf00d, 0, 1'b0);
        txn("lw_1c",  1'b0, 32'h1C, 3'b010, 32'h0, 0, 1'b0);
    endtask

    task automatic test_misaligned();
        txn("lw_a9",   1'b0, 32'hA9, 3'b010, 32'h0, 0, 1'b0);
        txn("sw_aa",   1'b1, 32'hAA, 3'b010, 32'h77777777, 0, 1'b0);
        txn("lh_a9",   1'b0, 32'hA9, 3'b001, 32'h0, 0, 1'b0);
        txn("f3_011",  1'b0, 32'hA8, 3'b011, 32'h0, 0, 1'b0);
        txn("sbu_a8",  1'b1, 32'hA8, 3'b100, 32'h99999999, 0, 1'b0);
        txn("lw_after", 1'b0, 32'hA8, 3'b010, 32'h0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        txn("lw_hold", 1'b0, 32'hA8, 3'b010, 32'h0, 3, 1'b1);
        txn("lw_post", 1'b0, 32'hA8, 3'b010, 32'h0, 0, 1'b0);
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hA8; req_funct3 = 3'b010; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        txn("lw_old", 1'b0, 32'hA8, 3'b010, 32'h0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            txn("b2b", i[0], 32'h200 + 32'(i / 2) * 4, 3'b010, 32'h1000 + 32'(i), 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_sizes();
        test_store();
        test_misaligned();
        test_backpressure();
        test_reset_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
